// File: rtl/fft_loader_pkg.sv
// Shared types and helpers for the FFT input loader: controller states and
// the index bit-reversal used to build the FFT RAM write address.
package fft_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Reverse the low 'width' bits of idx; bits at and above 'width' come back 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx,
                                              input int unsigned width);
    logic [31:0] rev;
    rev = '0;
    for (int unsigned i = 0; i < width; i++) begin
      rev[5'(i)] = idx[5'(width - 1 - i)];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Maps a natural-order sample index to the bit-reversed FFT RAM address.
// The extra top address bit selects the upper RAM half and is always 0 here.
module fft_bitrev_addr
  import fft_loader_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] idx_i,
  output logic [SIZE:0]   addr_o
);

  localparam int unsigned AW = SIZE + 1;

  assign addr_o = AW'(bit_reverse(32'(idx_i), SIZE));

endmodule

// File: rtl/fft_input_loader.sv
// Streams one frame of N complex samples into the FFT input RAM in
// bit-reversed order, zero-pads short frames, starts the FFT and gates the
// result readout. Optional prescale is enabled by FFT_LOADER_PRESCALE_EN.
module fft_input_loader
  import fft_loader_pkg::*;
#(
  parameter int unsigned bit_width      = 29,
  parameter int unsigned N              = 16,
  parameter int unsigned SIZE           = 4,
  parameter int unsigned PRESCALE_SHIFT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [bit_width-1:0] s_re,
  input  logic signed [bit_width-1:0] s_im,
  input  logic                        s_last,
  output logic                        load_data,
  output logic [SIZE:0]               invert_addr,
  output logic signed [bit_width-1:0] Re_o,
  output logic signed [bit_width-1:0] Im_o,
  output logic                        start_flag,
  input  logic                        finish_FFT,
  output logic                        en_out_data,
  input  logic                        fft_en_o,
  output logic                        busy,
  output logic                        frame_err
);

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);

  // Elaboration-time sanity checks on the configuration.
  if (N != (1 << SIZE)) begin : g_size_chk
    $error("N must equal 2**SIZE");
  end
  if (PRESCALE_SHIFT >= bit_width) begin : g_shift_chk
    $error("PRESCALE_SHIFT must be smaller than bit_width");
  end

  state_e                      state_q;
  logic [SIZE-1:0]             cnt_q;
  logic [SIZE-1:0]             drain_q;
  logic                        load_q;
  logic [SIZE:0]               addr_q;
  logic signed [bit_width-1:0] re_q;
  logic signed [bit_width-1:0] im_q;
  logic                        start_q;
  logic                        en_q;
  logic                        err_q;

  logic [SIZE:0]               addr_d;
  logic signed [bit_width-1:0] re_d;
  logic signed [bit_width-1:0] im_d;
  logic                        accept_c;

  fft_bitrev_addr #(
    .SIZE (SIZE)
  ) u_bitrev (
    .idx_i  (cnt_q),
    .addr_o (addr_d)
  );

`ifdef FFT_LOADER_PRESCALE_EN
  // Sign-preserving truncating shift buys headroom for FFT bit growth.
  assign re_d = s_re >>> PRESCALE_SHIFT;
  assign im_d = s_im >>> PRESCALE_SHIFT;
`else
  assign re_d = s_re;
  assign im_d = s_im;
`endif

  assign s_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept_c = s_valid && s_ready;

  // Controller: cnt_q is the write index for both live samples and padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept_c) begin
            load_q <= 1'b1;
            addr_q <= addr_d;
            re_q   <= re_d;
            im_q   <= im_d;
            if (cnt_q == LAST_IDX) begin
              err_q   <= !s_last;
              cnt_q   <= '0;
              state_q <= ST_START;
            end else if (s_last) begin
              err_q   <= 1'b1;
              cnt_q   <= cnt_q + ONE;
              state_q <= ST_PAD;
            end else begin
              cnt_q   <= cnt_q + ONE;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_PAD: begin
          load_q <= 1'b1;
          addr_q <= addr_d;
          re_q   <= '0;
          im_q   <= '0;
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        ST_START: begin
          start_q <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (finish_FFT) begin
            en_q    <= 1'b1;
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fft_en_o) begin
            if (drain_q == LAST_IDX) begin
              drain_q <= '0;
              en_q    <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              drain_q <= drain_q + ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign load_data   = load_q;
  assign invert_addr = addr_q;
  assign Re_o        = re_q;
  assign Im_o        = im_q;
  assign start_flag  = start_q;
  assign en_out_data = en_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized bench for fft_input_loader: a frame-level reference model
// predicts every RAM write, the start pulse, framing errors and the drain.
module tb_fft_input_loader;

  localparam int unsigned W    = 29;
  localparam int unsigned N    = 16;
  localparam int unsigned SIZE = 4;
  localparam int unsigned PS   = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_re;
  logic signed [W-1:0] s_im;
  logic                s_last;
  logic                load_data;
  logic [SIZE:0]       invert_addr;
  logic signed [W-1:0] Re_o;
  logic signed [W-1:0] Im_o;
  logic                start_flag;
  logic                finish_FFT;
  logic                en_out_data;
  logic                fft_en_o;
  logic                busy;
  logic                frame_err;

  fft_input_loader #(
    .bit_width      (W),
    .N              (N),
    .SIZE           (SIZE),
    .PRESCALE_SHIFT (PS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_re        (s_re),
    .s_im        (s_im),
    .s_last      (s_last),
    .load_data   (load_data),
    .invert_addr (invert_addr),
    .Re_o        (Re_o),
    .Im_o        (Im_o),
    .start_flag  (start_flag),
    .finish_FFT  (finish_FFT),
    .en_out_data (en_out_data),
    .fft_en_o    (fft_en_o),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int re;
    int im;
  } wr_t;

  wr_t                 exp_q[$];
  int                  obs_addr[$];
  int                  obs_re[$];
  int                  cyc = 0;
  int                  first_wr = 0;
  int                  last_wr = 0;
  int                  start_cnt = 0;
  int                  err_cnt = 0;
  int                  n_chk = 0;
  int                  n_bad = 0;
  logic signed [W-1:0] re_a[N];
  logic signed [W-1:0] im_a[N];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_rev(input int k);
    int r = 0;
    for (int b = 0; b < int'(SIZE); b++)
      if (((k >> b) & 1) == 1) r += 1 << (int'(SIZE) - 1 - b);
    return r;
  endfunction

  // Floor division by 2**PS when prescale is compiled in.
  function automatic int ref_scale(input int x);
`ifdef FFT_LOADER_PRESCALE_EN
    int d = 1 << PS;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < int'(N); k++) begin
      re_a[k] = W'($urandom());
      im_a[k] = W'($urandom());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_invert_addr"}, invert_addr, 0);
    chk({tag, "_re"}, Re_o, 0);
    chk({tag, "_im"}, Im_o, 0);
    chk({tag, "_start_flag"}, start_flag, 0);
    chk({tag, "_en_out_data"}, en_out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  // Write / start / error monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    wr_t e;
    if (load_data) begin
      if (obs_addr.size() == 0) first_wr = cyc;
      last_wr = cyc;
      obs_addr.push_back(int'(invert_addr));
      obs_re.push_back(int'(Re_o));
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", invert_addr, e.addr);
        chk("write_re", Re_o, e.re);
        chk("write_im", Im_o, e.im);
      end
    end
    if (start_flag) begin
      start_cnt++;
      chk("start_after_last_write", cyc - last_wr, 1);
      chk("writes_pending_at_start", exp_q.size(), 0);
    end
    if (frame_err) err_cnt++;
    cyc++;
  end

  task automatic run_frame(input int nb, input bit with_last, input bit bubbles,
                           input bit early_fin);
    int  e0;
    int  s0;
    int  t;
    wr_t w;
    obs_addr.delete();
    obs_re.delete();
    e0 = err_cnt;
    s0 = start_cnt;
    for (int k = 0; k < int'(N); k++) begin
      w.addr = ref_rev(k);
      w.re   = (k < nb) ? ref_scale(int'(re_a[k])) : 0;
      w.im   = (k < nb) ? ref_scale(int'(im_a[k])) : 0;
      exp_q.push_back(w);
    end
    for (int b = 0; b < nb; b++) begin
      if (bubbles) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      chk("s_ready_in_frame", s_ready, 1);
      s_valid    = 1'b1;
      s_re       = re_a[b];
      s_im       = im_a[b];
      s_last     = with_last && (b == nb - 1);
      finish_FFT = early_fin && (b == 3);
      tick();
    end
    s_valid    = 1'b0;
    s_last     = 1'b0;
    finish_FFT = 1'b0;
    if (nb < int'(N)) begin
      @(negedge clk);
      chk("s_ready_pad", s_ready, 0);
      chk("busy_pad", busy, 1);
    end
    t = 0;
    while (start_cnt == s0 && t < 4 * int'(N)) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("start_count", start_cnt - s0, 1);
    chk("frame_err_count", err_cnt - e0, (with_last && nb == int'(N)) ? 0 : 1);
    repeat ($urandom_range(0, 4)) tick();
    chk("en_before_finish", en_out_data, 0);
    tick();
    finish_FFT = 1'b1;
    tick();
    finish_FFT = 1'b0;
    chk("en_after_finish", en_out_data, 1);
    for (int b = 0; b < int'(N); b++) begin
      repeat ($urandom_range(0, 2)) tick();
      chk("en_during_drain", en_out_data, 1);
      fft_en_o = 1'b1;
      tick();
      fft_en_o = 1'b0;
    end
    chk("en_after_drain", en_out_data, 0);
    chk("busy_after_drain", busy, 0);
    chk("s_ready_idle", s_ready, 1);
    chk("writes_left", exp_q.size(), 0);
  endtask

  task automatic reset_mid_frame();
    int  s0;
    wr_t w;
    fill_random();
    obs_addr.delete();
    obs_re.delete();
    s0 = start_cnt;
    for (int k = 0; k < 7; k++) begin
      w.addr = ref_rev(k);
      w.re   = ref_scale(int'(re_a[k]));
      w.im   = ref_scale(int'(im_a[k]));
      exp_q.push_back(w);
    end
    for (int b = 0; b < 7; b++) begin
      s_valid = 1'b1;
      s_re    = re_a[b];
      s_im    = im_a[b];
      s_last  = 1'b0;
      tick();
    end
    s_re = re_a[7];
    s_im = im_a[7];
    rst  = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    check_reset_outputs("mid_reset");
    repeat (N + 4) tick();
    chk("no_start_after_reset", start_cnt - s0, 0);
    chk("reset_writes_left", exp_q.size(), 0);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    bit wl;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_re       = '0;
    s_im       = '0;
    s_last     = 1'b0;
    finish_FFT = 1'b0;
    fft_en_o   = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Full frame at one beat per clock, with known prescale values first.
    fill_random();
    re_a[0] = -W'(5);
    re_a[1] = W'(6);
    run_frame(N, 1'b1, 1'b0, 1'b0);
    chk("full_addr_beat1", obs_addr[1], 8);
    chk("full_addr_beat3", obs_addr[3], 12);
    chk("full_write_span", last_wr - first_wr, N - 1);
`ifdef FFT_LOADER_PRESCALE_EN
    chk("prescale_neg5", obs_re[0], -3);
    chk("prescale_pos6", obs_re[1], 3);
`else
    chk("passthru_neg5", obs_re[0], -5);
    chk("passthru_pos6", obs_re[1], 6);
`endif

    // Early s_last on beat 9 -> zero padding.
    fill_random();
    run_frame(10, 1'b1, 1'b0, 1'b0);
    chk("pad_addr_idx10", obs_addr[10], 5);
    chk("pad_addr_idx11", obs_addr[11], 13);
    chk("pad_addr_idx15", obs_addr[15], 15);

    // Bubbles plus a stray finish_FFT during load.
    fill_random();
    run_frame(N, 1'b1, 1'b1, 1'b1);

    // Missing s_last on the final beat, then a single-beat frame.
    fill_random();
    run_frame(N, 1'b0, 1'b0, 1'b0);
    fill_random();
    run_frame(1, 1'b1, 1'b0, 1'b0);

    // Reset mid-frame, then a clean frame from index 0.
    reset_mid_frame();
    fill_random();
    run_frame(N, 1'b1, 1'b0, 1'b0);
    chk("post_reset_first_addr", obs_addr[0], 0);

    for (int f = 0; f < 8; f++) begin
      fill_random();
      wl = 1'($urandom_range(0, 3) != 0);
      nb = wl ? int'($urandom_range(1, N)) : int'(N);
      run_frame(nb, wl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter bit_width, default 29: sample word width, equal to the FFT core's data width.
REQ-002 Parameter N, default 16: FFT points per frame.
REQ-003 Parameter SIZE, default 4: log2(N).
REQ-004 Parameter PRESCALE_SHIFT, default 1: arithmetic right-shift applied when prescale is compiled in.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_valid  in  1  upstream sample valid.
REQ-008 s_ready  out  1  loader accepts a sample this cycle.
REQ-009 s_re / s_im  in  bit_width each  signed sample, real and imaginary.
REQ-010 s_last  in  1  marks the upstream frame's final sample.
REQ-011 load_data  out  1  write strobe into the FFT input RAM.
REQ-012 invert_addr  out  SIZE+1  bit-reversed write address; bit SIZE is always 0.
REQ-013 Re_o / Im_o  out  bit_width each  signed sample written with load_data.
REQ-014 start_flag  out  1  one-cycle FFT start pulse.
REQ-015 finish_FFT  in  1  FFT computation done.
REQ-016 en_out_data  out  1  enables FFT result readout.
REQ-017 fft_en_o  in  1  FFT output beat valid.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 frame_err  out  1  one-cycle pulse on a framing violation.

Function
REQ-020 FSM states: IDLE, LOAD, PAD, START, RUN, DRAIN.
REQ-021 IDLE->LOAD on the first accepted beat; that beat is loaded with index 0.
REQ-022 Beat acceptance: s_valid && s_ready; s_ready = 1 in IDLE and LOAD only.
REQ-023 Each accepted beat at index k drives one write cycle, registered one cycle later: load_data=1, invert_addr = bit-reverse of k over SIZE bits, Re_o/Im_o = sample.
REQ-024 load_data = 0 in every cycle without a write.
REQ-025 k wraps 0..N-1; accepting index N-1 moves LOAD->START.
REQ-026 s_last on index N-1: normal termination.
REQ-027 s_last absent on index N-1: frame_err pulses and the frame proceeds normally; the next beat starts a new frame.
REQ-028 s_last on index k<N-1: frame_err pulses and the FSM moves to PAD.
REQ-029 PAD writes zero samples to indices k+1..N-1, one per cycle, with s_ready=0, then moves to START.
REQ-030 START: start_flag=1 for exactly one cycle, which is the cycle after the last load_data; the FSM then moves to RUN.
REQ-031 RUN waits for finish_FFT, then moves to DRAIN; finish_FFT is ignored in every other state.
REQ-032 DRAIN: en_out_data=1 while N fft_en_o beats are counted; after the Nth beat en_out_data drops next cycle and the FSM moves to IDLE.
REQ-033 Sustained throughput: one sample per clock, with no bubbles inside a frame.
REQ-034 Frame-to-frame gap: at least from START through DRAIN.

Reset
REQ-035 On rst: state=IDLE, counters=0, and every output = 0 except s_ready, which is 1.
REQ-036 rst asserted mid-frame discards the partial frame; no start_flag is issued.

Configuration
REQ-037 Feature macro FFT_LOADER_PRESCALE_EN.
REQ-038 Macro defined: Re_o = s_re >>> PRESCALE_SHIFT and Im_o = s_im >>> PRESCALE_SHIFT (sign-preserving, truncating), giving FFT growth headroom.
REQ-039 Macro undefined: samples pass unmodified; PRESCALE_SHIFT is unused.

Structure
REQ-040 Package fft_loader_pkg holds the state enum and the bit-reverse function.
REQ-041 One sub-module, fft_bitrev_addr, maps index to invert_addr combinationally.

Verification
REQ-042 N=16, 16 beats at 1/clk, s_last on beat 15 -> load_data on 16 consecutive cycles; beat 1 uses invert_addr=8 and beat 3 uses 12; start_flag one cycle later; frame_err=0.
REQ-043 s_last on beat 9 -> frame_err pulse; zeros written to indices 10..15 (invert_addr 5,13,3,11,7,15); s_ready=0 during PAD; start_flag follows.
REQ-044 finish_FFT pulsed during LOAD -> ignored. In RUN, finish_FFT -> en_out_data high until the 16th fft_en_o, low the next cycle, busy=0.
REQ-045 rst at beat 7 -> next cycle all outputs 0, s_ready=1; the following full frame loads from index 0 correctly.
REQ-046 FFT_LOADER_PRESCALE_EN with PRESCALE_SHIFT=1: s_re=-5 -> Re_o=-3; s_re=6 -> Re_o=3. Macro off: -5 -> -5.
